// File: rtl/data_mem_responder.sv
// Single-port word memory behind a 3-state request/response handshake with programmable wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memread_ctrl,
   input  logic        memwrite_ctrl,
   input  logic [31:0] data_mem_addr,
   input  logic [31:0] data_mem_wrdata,
   output logic [31:0] data_mem_rd_data,
   output logic        mem_ready,
   output logic        mem_err,
   output logic        mem_busy
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic          err;
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
   } req_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   req_t          req, req_nxt;
   logic          accept;
   logic          out_of_range;
   logic          misaligned;
   logic [31:0]   mem [DEPTH_WORDS];

   // Any address bit above the index width means the word lies past the end of storage.
   assign out_of_range = |data_mem_addr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = |data_mem_addr[1:0];
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^data_mem_addr[1:0];
   assign misaligned      = 1'b0;
`endif

   assign accept = (state == IDLE) && (memread_ctrl || memwrite_ctrl);

   always_comb begin
      req_nxt       = '0;
      req_nxt.rd    = memread_ctrl;
      req_nxt.wr    = memwrite_ctrl;
      req_nxt.err   = (memread_ctrl && memwrite_ctrl) || out_of_range || misaligned;
      req_nxt.idx   = data_mem_addr[AW+1:2];
      req_nxt.wdata = data_mem_wrdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         req   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) req <= req_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (WAIT_STATES > 0) begin
                  state_nxt = WAIT;
                  cnt_nxt   = WS_LOAD;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_ready        = 1'b0;
      mem_err          = 1'b0;
      mem_busy         = 1'b0;
      data_mem_rd_data = 32'd0;
      case (state)
         WAIT: mem_busy = 1'b1;
         RESP: begin
            mem_busy  = 1'b1;
            mem_ready = 1'b1;
            mem_err   = req.err;
            if (req.rd && !req.err) data_mem_rd_data = mem[req.idx];
         end
         default: ;
      endcase
   end

   // Storage has no reset; an async reset forces IDLE so a pending write never commits.
   always_ff @(posedge clk) begin
      if (state == RESP && req.wr && !req.err) mem[req.idx] <= req.wdata;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 1, 0, 3) checked against a word-array model.
module tb_data_mem_responder;

   localparam int DEPTH = 32;
   localparam int NU    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd   [NU];
   logic        wr   [NU];
   logic [31:0] addr [NU];
   logic [31:0] wd   [NU];
   logic [31:0] rdd  [NU];
   logic        rdy  [NU];
   logic        err  [NU];
   logic        busy [NU];

   logic [31:0] mdl [NU][DEPTH];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          align_en;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n), .memread_ctrl(rd[0]), .memwrite_ctrl(wr[0]),
      .data_mem_addr(addr[0]), .data_mem_wrdata(wd[0]), .data_mem_rd_data(rdd[0]),
      .mem_ready(rdy[0]), .mem_err(err[0]), .mem_busy(busy[0]));

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .memread_ctrl(rd[1]), .memwrite_ctrl(wr[1]),
      .data_mem_addr(addr[1]), .data_mem_wrdata(wd[1]), .data_mem_rd_data(rdd[1]),
      .mem_ready(rdy[1]), .mem_err(err[1]), .mem_busy(busy[1]));

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .memread_ctrl(rd[2]), .memwrite_ctrl(wr[2]),
      .data_mem_addr(addr[2]), .data_mem_wrdata(wd[2]), .data_mem_rd_data(rdd[2]),
      .mem_ready(rdy[2]), .mem_err(err[2]), .mem_busy(busy[2]));

   function automatic int ws_of(input int u);
      return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_req(input int u, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
      bit          exp_e;
      logic [31:0] exp_d;
      int          lat;
      bit          seen;
      exp_e = (r && w) || (a[31:2] >= DEPTH) || (align_en && a[1:0] != 2'b00);
      exp_d = (r && !w && !exp_e) ? mdl[u][a[6:2]] : 32'd0;
      rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d;
      @(posedge clk);
      @(negedge clk);
      // Scramble inputs while the request is held; they must be ignored.
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = $urandom; wd[u] = $urandom;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat <= 20) begin
         if (rdy[u]) seen = 1'b1;
         else begin
            chk($sformatf("u%0d busy_wait", u), {31'd0, busy[u]}, 32'd1);
            chk($sformatf("u%0d rd_zero_wait", u), rdd[u], 32'd0);
            @(negedge clk);
            lat++;
         end
      end
      chk($sformatf("u%0d latency a=%h", u, a), lat, ws_of(u) + 1);
      if (seen) begin
         chk($sformatf("u%0d busy_resp", u), {31'd0, busy[u]}, 32'd1);
         chk($sformatf("u%0d err a=%h", u, a), {31'd0, err[u]}, {31'd0, exp_e});
         chk($sformatf("u%0d rdata a=%h", u, a), rdd[u], exp_d);
      end
      if (w && !r && !exp_e) mdl[u][a[6:2]] = d;
      @(negedge clk);
      chk($sformatf("u%0d ready_pulse", u), {31'd0, rdy[u]}, 32'd0);
      chk($sformatf("u%0d idle_busy", u), {31'd0, busy[u]}, 32'd0);
      chk($sformatf("u%0d idle_rd_zero", u), rdd[u], 32'd0);
   endtask

   task automatic chk_quiet(input int u, input string tag);
      chk({tag, " ready"}, {31'd0, rdy[u]}, 32'd0);
      chk({tag, " err"},   {31'd0, err[u]}, 32'd0);
      chk({tag, " busy"},  {31'd0, busy[u]}, 32'd0);
      chk({tag, " rdata"}, rdd[u], 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          k;
`ifdef DMEM_ALIGN_CHECK_EN
      align_en = 1'b1;
`else
      align_en = 1'b0;
`endif
      for (int u = 0; u < NU; u++) begin
         rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wd[u] = '0;
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < NU; u++) chk_quiet(u, $sformatf("u%0d reset", u));
      rst_n = 1'b1;

      // Fill every word so all later reads have a defined expectation.
      for (int u = 0; u < NU; u++)
         for (int i = 0; i < DEPTH; i++) do_req(u, 1'b0, 1'b1, 32'(i * 4), $urandom);

      // WAIT_STATES=1 write/read round trip.
      do_req(0, 1'b0, 1'b1, 32'h0C, 32'h5);
      do_req(0, 1'b1, 1'b0, 32'h0C, 32'h0);

      // WAIT_STATES=0 back-to-back reads.
      do_req(1, 1'b0, 1'b1, 32'h00, 32'h1);
      do_req(1, 1'b0, 1'b1, 32'h04, 32'h5);
      do_req(1, 1'b1, 1'b0, 32'h00, 32'h0);
      do_req(1, 1'b1, 1'b0, 32'h04, 32'h0);

      // Out of range: 0x80 must not alias onto word 0.
      do_req(0, 1'b1, 1'b0, 32'h80, 32'h0);
      do_req(0, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF);
      do_req(0, 1'b1, 1'b0, 32'h00, 32'h0);

      // Read and write together.
      do_req(0, 1'b1, 1'b1, 32'h08, 32'hCAFEF00D);
      do_req(0, 1'b1, 1'b0, 32'h08, 32'h0);

      // Reset in the second WAIT cycle of a WAIT_STATES=3 write.
      do_req(2, 1'b0, 1'b1, 32'h10, 32'h0);
      rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h10; wd[2] = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      wr[2] = 1'b0;
      @(posedge clk);
      #1;
      chk("u2 busy_before_reset", {31'd0, busy[2]}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_quiet(2, "u2 async_reset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("u2 no_ready_in_reset", {31'd0, rdy[2]}, 32'd0);
      end
      rst_n = 1'b1;
      do_req(2, 1'b1, 1'b0, 32'h10, 32'h0);

      // Misaligned write to word 1 then read back word 1.
      do_req(0, 1'b0, 1'b1, 32'h06, 32'hA5A55A5A);
      do_req(0, 1'b1, 1'b0, 32'h04, 32'h0);

      // Random mix against the model.
      for (int n = 0; n < 40; n++) begin
         for (int u = 0; u < NU; u++) begin
            case ($urandom % 4)
               0, 1:    a = {23'd0, 5'($urandom_range(0, 31)), 2'b00};
               2:       a = {23'd0, 5'($urandom_range(0, 31)), 2'($urandom)};
               default: a = ($urandom % 2) ? $urandom : 32'($urandom_range(32, 40) * 4);
            endcase
            k = $urandom % 5;
            do_req(u, (k < 2) || (k == 4), (k >= 2), a, $urandom);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
